// File: rtl/wb_trace_pkg.sv
// Shared types and helpers for the writeback trace buffer.
// Holds the FSM state encoding and the entry-width helper (WB_TRACE_TIMESTAMP_EN).
package wb_trace_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    FROZEN    = 2'd3
  } state_t;

`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int TS_ON = 1;
`else
  localparam int TS_ON = 0;
`endif

  // Entry layout is {ts, wm2reg, wdestReg, data}; ts only when enabled.
  function automatic int entry_w(
    input int ts_w,
    input int reg_aw,
    input int data_w
  );
    return ts_w * TS_ON + 1 + reg_aw + data_w;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Trace output stream: out_valid/out_ready handshake with out_data.
// master drives valid/data (buffer), slave drives ready (consumer).
interface wb_trace_buffer_if
  import wb_trace_pkg::*;
#(
  parameter int W = entry_w(16, 5, 32)
) ();

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// trace_fifo: first-word-fall-through FIFO with occupancy output.
// Ports: push/din, pop/dout/valid, full, level; async active-low reset.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (level == LW'(DEPTH));
  assign valid = (level != '0);
  // A pop frees the slot in the same edge, so push at full is legal then.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && valid;
  assign dout  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures register-file writes into a FWFT FIFO.
// Ports: wb inputs, arm/trigger control, tr stream, level/overflow/drop_cnt/state.
// Option WB_TRACE_TIMESTAMP_EN adds a TS_W cycle-counter field to each entry.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 16,
  parameter int TS_W         = 16,
  parameter int STOP_ON_FULL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wwreg,
  input  logic                   wm2reg,
  input  logic [REG_AW-1:0]      wdestReg,
  input  logic [DATA_W-1:0]      wr,
  input  logic [DATA_W-1:0]      wdo,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [REG_AW-1:0]      trig_reg,
  wb_trace_buffer_if.master      tr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [1:0]             state
);

  localparam int ENTRY_W = entry_w(TS_W, REG_AW, DATA_W);
  localparam int LW      = $clog2(DEPTH) + 1;

  state_t             st;
  logic               ev;
  logic               hit;
  logic               push;
  logic               pop;
  logic               full;
  logic               fits;
  logic               grow;
  logic [DATA_W-1:0]  data;
  logic [ENTRY_W-1:0] entry;
  logic [LW-1:0]      lvl_nx;

  assign ev   = wwreg && (wdestReg != '0);
  assign hit  = ev && (wdestReg == trig_reg);
  assign data = wm2reg ? wdo : wr;
  assign push = (st == CAPTURE && ev)
             || (st == WAIT_TRIG && hit);
  assign pop  = tr.out_valid && tr.out_ready;
  assign fits = !full || pop;
  assign grow = push && fits;
  assign lvl_nx = level + LW'(grow) - LW'(pop);
  assign state = st;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  assign entry = {ts, wm2reg, wdestReg, data};
`else
  assign entry = {wm2reg, wdestReg, data};
`endif

  trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .dout  (tr.out_data),
    .valid (tr.out_valid),
    .full  (full),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push && !fits) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
      case (st)
        IDLE: begin
          if (arm) begin
            st       <= trig_en ? WAIT_TRIG : CAPTURE;
            overflow <= 1'b0;
            drop_cnt <= '0;
          end
        end
        WAIT_TRIG: begin
          if (arm)
            st <= IDLE;
          else if (hit)
            st <= (STOP_ON_FULL != 0 && grow
                   && lvl_nx == LW'(DEPTH))
                  ? FROZEN : CAPTURE;
        end
        CAPTURE: begin
          if (arm)
            st <= IDLE;
          else if (STOP_ON_FULL != 0 && grow
                   && lvl_nx == LW'(DEPTH))
            st <= FROZEN;
        end
        FROZEN: begin
          if (lvl_nx == '0) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer (DEPTH=4, freeze and drop variants).
// Drives inputs on negedge, samples on the following negedge.
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  localparam int EW = entry_w(16, 5, 32);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wwreg;
  logic        wm2reg;
  logic [4:0]  wdestReg;
  logic [31:0] wr;
  logic [31:0] wdo;
  logic        arm_a;
  logic        arm_b;
  logic        trig_en;
  logic [4:0]  trig_reg;
  logic [2:0]  lvl_a;
  logic [2:0]  lvl_b;
  logic        ovf_a;
  logic        ovf_b;
  logic [15:0] dc_a;
  logic [15:0] dc_b;
  logic [1:0]  st_a;
  logic [1:0]  st_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_trace_buffer_if #(.W(EW)) ifa ();
  wb_trace_buffer_if #(.W(EW)) ifb ();

  wb_trace_buffer #(
    .DEPTH        (4),
    .STOP_ON_FULL (1)
  ) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wwreg    (wwreg),
    .wm2reg   (wm2reg),
    .wdestReg (wdestReg),
    .wr       (wr),
    .wdo      (wdo),
    .arm      (arm_a),
    .trig_en  (trig_en),
    .trig_reg (trig_reg),
    .tr       (ifa),
    .level    (lvl_a),
    .overflow (ovf_a),
    .drop_cnt (dc_a),
    .state    (st_a)
  );

  wb_trace_buffer #(
    .DEPTH        (4),
    .STOP_ON_FULL (0)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wwreg    (wwreg),
    .wm2reg   (wm2reg),
    .wdestReg (wdestReg),
    .wr       (wr),
    .wdo      (wdo),
    .arm      (arm_b),
    .trig_en  (trig_en),
    .trig_reg (trig_reg),
    .tr       (ifb),
    .level    (lvl_b),
    .overflow (ovf_b),
    .drop_cnt (dc_b),
    .state    (st_b)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [63:0] ent(
    input logic        m,
    input logic [4:0]  r,
    input logic [31:0] d
  );
    return {26'd0, m, r, d};
  endfunction

  task automatic ev(
    input logic [4:0]  r,
    input logic        m,
    input logic [31:0] a,
    input logic [31:0] d
  );
    @(negedge clk);
    wwreg = 1'b1; wdestReg = r; wm2reg = m;
    wr = a; wdo = d;
    @(negedge clk);
    wwreg = 1'b0;
  endtask

  task automatic arm_p(input logic b);
    @(negedge clk);
    if (b) arm_b = 1'b1;
    else   arm_a = 1'b1;
    @(negedge clk);
    arm_a = 1'b0;
    arm_b = 1'b0;
  endtask

  task automatic pop_p(input logic b);
    @(negedge clk);
    if (b) ifb.out_ready = 1'b1;
    else   ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wwreg = 1'b0; wm2reg = 1'b0;
    wdestReg = '0; wr = '0; wdo = '0;
    arm_a = 1'b0; arm_b = 1'b0;
    trig_en = 1'b0; trig_reg = '0;
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    #12;
    check("rst_state", 64'(st_a), 64'd0);
    check("rst_level", 64'(lvl_a), 64'd0);
    check("rst_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_data", 64'(ifa.out_data), 64'd0);
    check("rst_ovf", 64'(ovf_b), 64'd0);
    check("rst_dcnt", 64'(dc_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running capture, two entries in order.
    arm_p(0);
    check("arm_cap", 64'(st_a), 64'd2);
    ev(5'd8, 1'b0, 32'h11, 32'h0);
    ev(5'd9, 1'b1, 32'hdead, 32'h22);
    check("two_lvl", 64'(lvl_a), 64'd2);
    check("two_valid", 64'(ifa.out_valid), 64'd1);
    check("head_r8", 64'(ifa.out_data[37:0]),
          ent(1'b0, 5'd8, 32'h11));
    @(negedge clk);
    check("head_hold", 64'(ifa.out_data[37:0]),
          ent(1'b0, 5'd8, 32'h11));
    pop_p(0);
    check("second_r9", 64'(ifa.out_data[37:0]),
          ent(1'b1, 5'd9, 32'h22));
    pop_p(0);
    check("drained", 64'(lvl_a), 64'd0);
    check("drain_valid", 64'(ifa.out_valid), 64'd0);

    // r0 write is not an event.
    ev(5'd0, 1'b0, 32'h55, 32'h0);
    check("r0_level", 64'(lvl_a), 64'd0);
    arm_p(0);
    check("cap_to_idle", 64'(st_a), 64'd0);

    // Trigger on r5.
    trig_en = 1'b1; trig_reg = 5'd5;
    arm_p(0);
    check("wait_trig", 64'(st_a), 64'd1);
    ev(5'd3, 1'b0, 32'h33, 32'h0);
    check("r3_state", 64'(st_a), 64'd1);
    check("r3_level", 64'(lvl_a), 64'd0);
    ev(5'd5, 1'b0, 32'h55, 32'h0);
    check("trig_state", 64'(st_a), 64'd2);
    check("trig_level", 64'(lvl_a), 64'd1);
    check("trig_entry", 64'(ifa.out_data[37:0]),
          ent(1'b0, 5'd5, 32'h55));
    arm_p(0);
    check("disarm_keep", 64'(lvl_a), 64'd1);
    pop_p(0);
    trig_en = 1'b0;

    // Freeze when full.
    arm_p(0);
    for (int i = 1; i <= 4; i++)
      ev(5'(i), 1'b0, 32'h100 + 32'(i), 32'h0);
    check("frozen_at4", 64'(st_a), 64'd3);
    ev(5'd5, 1'b0, 32'h105, 32'h0);
    ev(5'd6, 1'b0, 32'h106, 32'h0);
    check("frz_level", 64'(lvl_a), 64'd4);
    check("frz_head", 64'(ifa.out_data[37:0]),
          ent(1'b0, 5'd1, 32'h101));
    arm_p(0);
    check("frz_arm_ign", 64'(st_a), 64'd3);
    for (int i = 0; i < 3; i++) pop_p(0);
    check("frz_lvl1", 64'(lvl_a), 64'd1);
    check("frz_still", 64'(st_a), 64'd3);
    check("frz_last", 64'(ifa.out_data[37:0]),
          ent(1'b0, 5'd4, 32'h104));
    pop_p(0);
    check("frz_idle", 64'(st_a), 64'd0);
    check("frz_empty", 64'(lvl_a), 64'd0);

    // Drop mode.
    arm_p(1);
    for (int i = 1; i <= 7; i++)
      ev(5'(i), 1'b0, 32'h200 + 32'(i), 32'h0);
    check("drop_state", 64'(st_b), 64'd2);
    check("drop_level", 64'(lvl_b), 64'd4);
    check("drop_ovf", 64'(ovf_b), 64'd1);
    check("drop_cnt", 64'(dc_b), 64'd3);
    @(negedge clk);
    wwreg = 1'b1; wdestReg = 5'd10; wm2reg = 1'b0;
    wr = 32'h2aa;
    ifb.out_ready = 1'b1;
    @(negedge clk);
    wwreg = 1'b0;
    ifb.out_ready = 1'b0;
    check("pp_level", 64'(lvl_b), 64'd4);
    check("pp_nodrop", 64'(dc_b), 64'd3);
    check("pp_head", 64'(ifb.out_data[31:0]), 64'h202);
    arm_p(1);
    check("ovf_kept", 64'(ovf_b), 64'd1);
    arm_p(1);
    check("ovf_clr", 64'(ovf_b), 64'd0);
    check("dcnt_clr", 64'(dc_b), 64'd0);
    arm_p(1);

    // Async reset mid-capture.
    arm_p(0);
    for (int i = 1; i <= 3; i++)
      ev(5'(i), 1'b0, 32'h300 + 32'(i), 32'h0);
    check("pre_rst_lvl", 64'(lvl_a), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", 64'(lvl_a), 64'd0);
    check("arst_valid", 64'(ifa.out_valid), 64'd0);
    check("arst_state", 64'(st_a), 64'd0);
    check("arst_data", 64'(ifa.out_data), 64'd0);
    check("arst_lvl_b", 64'(lvl_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ev(5'd7, 1'b0, 32'h77, 32'h0);
    check("post_rst_idle", 64'(lvl_a), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, writeback data width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter DEPTH, default 16, trace entries; power of two, 2 or more.
REQ-004 SHALL have parameter TS_W, default 16, timestamp width.
REQ-005 SHALL have parameter STOP_ON_FULL, default 1: 1 means freeze when full; 0 means drop new entries and count them.
REQ-006 SHALL have ports as listed:
 clk  in  1  clock, rising edge.
 rst_n  in  1  reset, asynchronous, active-low.
 wwreg  in  1  writeback stage writes the register file.
 wm2reg  in  1  writeback data comes from memory.
 wdestReg  in  REG_AW  writeback destination register.
 wr  in  DATA_W  ALU result.
 wdo  in  DATA_W  memory load data.
 arm  in  1  single-cycle control pulse.
 trig_en  in  1  1 means wait for the trigger register before capturing.
 trig_reg  in  REG_AW  trigger destination register.
 out_valid  out  1  trace entry available.
 out_ready  in  1  consumer accepts the entry.
 out_data  out  ENTRY_W  trace entry.
 level  out  $clog2(DEPTH)+1  occupancy.
 overflow  out  1  sticky drop flag.
 drop_cnt  out  16  count of dropped events; saturates at 16'hFFFF.
 state  out  2  current FSM state.

Function
REQ-007 SHALL define an event as: wwreg=1 and wdestReg!=0 on a rising clk edge.
REQ-008 SHALL select event data as wdo when wm2reg=1, otherwise wr.
REQ-009 SHALL pack an entry as {ts, wm2reg, wdestReg, data}, with data in the LSBs.
REQ-010 SHALL use FSM states IDLE=0, WAIT_TRIG=1, CAPTURE=2, FROZEN=3.
REQ-011 SHALL, in IDLE, go to WAIT_TRIG when arm=1 and trig_en=1; go to CAPTURE when arm=1 and trig_en=0; otherwise remain in IDLE.
REQ-012 SHALL, in WAIT_TRIG, go to CAPTURE on an event with wdestReg==trig_reg, and SHALL capture that triggering event.
REQ-013 SHALL push every event while in CAPTURE.
REQ-014 SHALL, with STOP_ON_FULL=1, enter FROZEN on the edge at which a push makes level==DEPTH.
REQ-015 SHALL, with STOP_ON_FULL=0, stay in CAPTURE; an event arriving while full with no pop SHALL be dropped, set overflow and increment drop_cnt.
REQ-016 SHALL return to IDLE on arm=1 while in WAIT_TRIG or CAPTURE; FIFO contents SHALL be retained.
REQ-017 SHALL, in FROZEN, return to IDLE on the edge at which level becomes 0; arm SHALL be ignored in FROZEN.
REQ-018 SHALL present the FIFO as first-word-fall-through: a pushed entry drives out_valid=1 on the cycle after the push edge (latency 1).
REQ-019 SHALL pop on the edge where out_valid=1 and out_ready=1; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on simultaneous push and pop at level==DEPTH, accept both; level SHALL be unchanged and no drop SHALL occur.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH.
REQ-022 SHALL clear overflow and drop_cnt on the arm pulse that leaves IDLE.
REQ-023 SHALL use ts from a TS_W free-running cycle counter that wraps to 0.

Reset
REQ-024 SHALL, with rst_n=0, asynchronously set: state=IDLE, both pointers=0, level=0, out_valid=0, overflow=0, drop_cnt=0, ts counter=0.
REQ-025 SHALL keep out_data at 0 while out_valid=0 after reset.
REQ-026 SHALL discard in-flight contents when reset is asserted mid-capture, with no partial entry emitted.

Configuration
REQ-027 SHALL include the ts field when WB_TRACE_TIMESTAMP_EN is defined: ENTRY_W=TS_W+1+REG_AW+DATA_W.
REQ-028 SHALL, when WB_TRACE_TIMESTAMP_EN is undefined, omit the ts field and the counter: ENTRY_W=1+REG_AW+DATA_W.

Structure
REQ-029 SHALL place the FSM state encoding and the entry-width function in package wb_trace_pkg.
REQ-030 SHALL implement storage as sub-module trace_fifo (parametrised width/depth, FWFT, level output).

Verification
REQ-031 SHALL cover: arm with trig_en=0; events to r8 (wr=0x11), then r9 (wm2reg=1, wdo=0x22) -> two entries in order, data 0x11, 0x22.
REQ-032 SHALL cover: event wwreg=1 with wdestReg=0 in CAPTURE -> no entry; level stays 0.
REQ-033 SHALL cover: trig_en=1, trig_reg=5; events to r3 then r5 -> only the r5 entry is captured; state goes 1->2.
REQ-034 SHALL cover: DEPTH=4, STOP_ON_FULL=1, 6 events with out_ready=0 -> level=4, state=3; draining all 4 entries -> state=0.
REQ-035 SHALL cover: DEPTH=4, STOP_ON_FULL=0, 7 events with out_ready=0 -> overflow=1, drop_cnt=3; a push together with a pop at full -> no drop.
REQ-036 SHALL cover: rst_n asserted mid-capture at level=3 -> level=0, out_valid=0, state=0 immediately, without waiting for a clock edge.
